// File: rtl/alu_retire_ctrl.sv
// alu_retire_ctrl
//   Issues one decoded operation at a time to the ALU by bumping the shared
//   instruction counter. It then waits for the ALU to echo that counter and
//   retires the result: register writeback, carry flag update, and selection
//   of either the next PC or the branch target.
//
// Ports
//   clk, reset       system clock; synchronous active-low reset
//   op_*             decoded operation from the decoder (op_ready handshake)
//   issue_ctr        instruction counter driven to the register file / ALU
//   alu_op_out       opcode driven to the ALU
//   alu_*            ALU result, carry, branch flag and counter echo
//   carry_q          stored carry flag, fed back to the ALU carry input
//   wr_en/addr/data  register-file write port (one-cycle strobe)
//   pc, pc_load      program counter and taken-branch pulse
//   retired          one-cycle pulse per retired operation
//   timeout_err      sticky flag: the ALU never echoed the counter
//
// state  | meaning
// IDLE   | op_ready high, waiting for the decoder
// WAIT   | operation issued, waiting for alu_ctr to match issue_ctr
// RETIRE | pulses are out; commit carry and pc, then back to IDLE
module alu_retire_ctrl #(
  parameter int CTR_W   = 12,
  parameter int PC_W    = 10,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_alu,
  input  logic             op_wr_en,
  input  logic [2:0]       op_wr_addr,
  input  logic [PC_W-1:0]  op_branch_tgt,
  output logic [CTR_W-1:0] issue_ctr,
  output logic [3:0]       alu_op_out,
  input  logic [7:0]       alu_rslt,
  input  logic             alu_shiftcarry,
  input  logic             alu_branch,
  input  logic [CTR_W-1:0] alu_ctr,
  output logic             carry_q,
  output logic             wr_en,
  output logic [2:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic [PC_W-1:0]  pc,
  output logic             pc_load,
  output logic             retired,
  output logic             timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETIRE} state_t;

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [3:0]      alu_q;
  logic            wen_q;
  logic [2:0]      addr_q;
  logic [PC_W-1:0] tgt_q;
  logic            carry_cap;
  logic            branch_cap;
  logic [WCW-1:0]  wait_cnt;

  function automatic logic is_cmp(input logic [3:0] op);
    return op inside {4'd7, 4'd8, 4'd9, 4'd11, 4'd12};
  endfunction

  function automatic logic is_carry(input logic [3:0] op);
    return op inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd10};
  endfunction

  assign op_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      issue_ctr   <= '0;
      alu_op_out  <= 4'hF;
      carry_q     <= 1'b0;
      pc          <= '0;
      timeout_err <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      pc_load     <= 1'b0;
      retired     <= 1'b0;
      alu_q       <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      tgt_q       <= '0;
      carry_cap   <= 1'b0;
      branch_cap  <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      wr_en   <= 1'b0;
      pc_load <= 1'b0;
      retired <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            alu_q      <= op_alu;
            wen_q      <= op_wr_en;
            addr_q     <= op_wr_addr;
            tgt_q      <= op_branch_tgt;
            alu_op_out <= op_alu;
            issue_ctr  <= issue_ctr + 1'b1;
            wait_cnt   <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu_ctr == issue_ctr) begin
            // Pulses are registered here so they are visible during RETIRE.
            carry_cap  <= alu_shiftcarry;
            branch_cap <= alu_branch;
            wr_en      <= wen_q && !is_cmp(alu_q);
            wr_addr    <= addr_q;
            wr_data    <= alu_rslt;
            retired    <= 1'b1;
            pc_load    <= is_cmp(alu_q) && alu_branch;
            state      <= S_RETIRE;
          end else if (wait_cnt == WCW'(TIMEOUT - 2)) begin
            // This miss would bring the count to TIMEOUT-1: abandon the op.
            timeout_err <= 1'b1;
            pc          <= pc + 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RETIRE: begin
          if (is_carry(alu_q))
            carry_q <= carry_cap;
          if (is_cmp(alu_q) && branch_cap)
            pc <= tgt_q;
          else
            pc <= pc + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_retire_ctrl.md
Name: alu_retire_ctrl

Overview:
- Consumer end of the ALU result interface, and the owner of the instruction counter that the register file and ALU use to detect a new operation.
- Accepts one decoded operation at a time from the decoder and issues it by bumping the counter and driving the ALU opcode.
- Waits for the ALU to echo the counter back, then retires the result:
  - register writeback,
  - carry flag update (the flag feeds the ALU carry input),
  - next-PC or branch-target selection.
- Sits between the decoder, the ALU/register file, and the instruction fetch PC.

Parameters:
- CTR_W, 12: width of the instruction counter and of the ALU counter echo.
- PC_W, 10: program counter width.
- TIMEOUT, 16: maximum cycles spent in WAIT before the operation is abandoned.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- op_valid  in  1  decoder presents an operation.
- op_ready  out  1  block can accept an operation (high only in IDLE).
- op_alu  in  4  ALU opcode of the operation.
- op_wr_en  in  1  operation writes its result to the register file.
- op_wr_addr  in  3  destination register.
- op_branch_tgt  in  PC_W  absolute branch target for compare opcodes.
- issue_ctr  out  CTR_W  instruction counter, driven to the register file / ALU counter input.
- alu_op_out  out  4  opcode driven to the ALU.
- alu_rslt  in  8  ALU result.
- alu_shiftcarry  in  1  ALU carry/overflow out.
- alu_branch  in  1  ALU branch flag.
- alu_ctr  in  CTR_W  counter echoed by the ALU.
- carry_q  out  1  stored carry flag, to the ALU carry input.
- wr_en  out  1  register-file write strobe (one cycle).
- wr_addr  out  3  register-file write address.
- wr_data  out  8  register-file write data.
- pc  out  PC_W  current program counter.
- pc_load  out  1  one-cycle pulse on a taken branch.
- retired  out  1  one-cycle pulse per successful retirement.
- timeout_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (reset==0 at posedge clk):
  - State goes to IDLE.
  - issue_ctr=0, alu_op_out=4'hF, carry_q=0, pc=0, timeout_err=0.
  - wr_en, pc_load and retired are all 0; wr_addr=0, wr_data=0.
  - An operation in flight is discarded with no writeback.
- Opcode classes:
  - Compare: 7, 8, 9, 11, 12.
  - Carry-producing: 3, 4, 5, 6, 10.
  - Every other opcode is a plain write and leaves carry_q unchanged.
- IDLE:
  - op_ready=1.
  - On op_valid: latch op_alu, op_wr_en, op_wr_addr and op_branch_tgt; set alu_op_out<=op_alu; set issue_ctr<=issue_ctr+1 (modulo 2^CTR_W, so 2^CTR_W-1 wraps to 0); clear the wait counter; go to WAIT.
- WAIT:
  - op_ready=0; op_valid is ignored.
  - If alu_ctr==issue_ctr: capture alu_rslt, alu_shiftcarry and alu_branch; go to RETIRE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT-1 without a match: set timeout_err; pc<=pc+1; go to IDLE with no write and no retired pulse.
- RETIRE (exactly one cycle), then go to IDLE:
  - wr_en = latched op_wr_en AND opcode is not a compare. Compare opcodes never write, even if op_wr_en=1.
  - wr_addr and wr_data come from the latched address and the captured result.
  - carry_q <= captured carry, only for carry-producing opcodes.
  - Compare opcode with captured branch=1: pc<=latched target and pc_load=1.
  - Otherwise: pc<=pc+1, modulo 2^PC_W. The branch flag is ignored for non-compare opcodes.
  - retired=1.
- Latency:
  - Operation accepted at edge N.
  - Earliest match is sampled at edge N+1.
  - wr_en, retired and pc_load are high during the cycle after edge N+1.
  - pc is updated at edge N+2.
  - Throughput is at most one operation per 3 cycles.
- Output timing:
  - All outputs are decoded from state and registered values only; there is no combinational path from any input to any output.
  - op_ready is a pure function of state.
- alu_op_out holds its value until the next accepted operation.
- Reset asserted in any state takes priority over all other transitions.

Test Plan:
- Reset, then op_alu=5, op_wr_en=1, addr=2, ALU returns rslt=0x7F, carry=0, matching ctr -> issue_ctr=1; wr_en pulse with wr_addr=2, wr_data=0x7F; retired pulse 2 cycles after accept; pc 0->1; carry_q=0.
- op_alu=3 with alu_shiftcarry=1 -> carry_q=1 after retire; next op_alu=0 with alu_shiftcarry=0 -> carry_q stays 1.
- op_alu=7, op_wr_en=1, tgt=0x2A, alu_branch=1 -> wr_en stays 0, pc_load pulse, pc=0x2A. Repeat with alu_branch=0 -> pc=0x2B, no pc_load.
- TIMEOUT=16 with alu_ctr held stale -> timeout_err rises after 15 WAIT cycles; no wr_en or retired pulse; pc+1; op_ready high the next cycle; timeout_err stays 1 until reset.
- CTR_W=4, PC_W=4, 17 back-to-back operations with the echoing ALU model -> issue_ctr wraps 15->0 and pc wraps 15->0; all 17 retire correctly.
- reset driven low during WAIT -> at the next edge state is IDLE and every output is at its reset value; no wr_en ever pulses for the abandoned operation.
